// File: rtl/gpio_port_edge.sv
// Memory-mapped GPIO port: per-pin direction, synchronized inputs and
// polarity-selectable edge flags with a level interrupt.
module gpio_port_edge #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       GPort_busAddr,
  input  logic             GPort_busWr,
  input  logic             GPort_busEn,
  inout  wire  [15:0]      GPort_busData,
  inout  wire  [WIDTH-1:0] GPort_extPin,
  output logic             GPort_irq
);

  localparam logic [2:0] AddrDir   = 3'd0;
  localparam logic [2:0] AddrOut   = 3'd1;
  localparam logic [2:0] AddrIn    = 3'd2;
  localparam logic [2:0] AddrIen   = 3'd3;
  localparam logic [2:0] AddrIpol  = 3'd4;
  localparam logic [2:0] AddrIflag = 3'd5;
  localparam logic [2:0] AddrOtgl  = 3'd6;

  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] dir_q, out_q, ien_q, ipol_q, iflag_q, iflag_d, prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_val, wdata, clr_mask, evt;
  logic [WarmW-1:0] warm_q;
  logic             warm_done, wr_en, rd_en;
  logic [15:0]      rdata;

  assign wr_en     = GPort_busEn & GPort_busWr;
  assign rd_en     = rstn & GPort_busEn & ~GPort_busWr;
  assign wdata     = GPort_busData[WIDTH-1:0];
  assign in_val    = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WarmW'(WarmMax));

  if (WIDTH < 16) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^GPort_busData[15:WIDTH];
  end

  // Pads are sampled regardless of direction, so an output pin reads back its own level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= GPort_extPin;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Edges are ignored until IN and PREV both hold real pad samples.
  always_comb begin
    evt = '0;
    if (warm_done) begin
      evt = (in_val & ~prev_q & ipol_q) | (~in_val & prev_q & ~ipol_q);
    end
    clr_mask = '0;
    if (wr_en && (GPort_busAddr == AddrIflag)) clr_mask = wdata;
    iflag_d = (iflag_q & ~clr_mask) | evt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dir_q   <= '0;
      out_q   <= '0;
      ien_q   <= '0;
      ipol_q  <= '0;
      iflag_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      if (wr_en) begin
        case (GPort_busAddr)
          AddrDir:  dir_q  <= wdata;
          AddrOut:  out_q  <= wdata;
          AddrIen:  ien_q  <= wdata;
          AddrIpol: ipol_q <= wdata;
          AddrOtgl: out_q  <= out_q ^ wdata;
          default:  ;
        endcase
      end
      iflag_q <= iflag_d;
      prev_q  <= in_val;
      if (!warm_done) warm_q <= warm_q + WarmW'(1);
    end
  end

  always_comb begin
    rdata = '0;
    case (GPort_busAddr)
      AddrDir:   rdata[WIDTH-1:0] = dir_q;
      AddrOut:   rdata[WIDTH-1:0] = out_q;
      AddrIn:    rdata[WIDTH-1:0] = in_val;
      AddrIen:   rdata[WIDTH-1:0] = ien_q;
      AddrIpol:  rdata[WIDTH-1:0] = ipol_q;
      AddrIflag: rdata[WIDTH-1:0] = iflag_q;
      default:   rdata = '0;
    endcase
  end

  // Reset gates the read driver directly so the bus releases without a clock.
  assign GPort_busData = rd_en ? rdata : 16'bz;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign GPort_extPin[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  assign GPort_irq = |(iflag_q & ien_q);

endmodule

// File: tb/tb_gpio_port_edge.sv
// Directed bench for gpio_port_edge; pull-ups on every tristate net make Z read as 1.
module tb_gpio_port_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, wr, en, bus_oe, irq_a, irq_b;
  logic [2:0]  addr;
  logic [15:0] bus_val, pad_oe, pad_val, rd_a, rd_b;
  wire  [15:0] bus_a, bus_b, pads_a;
  wire  [3:0]  pads_b;
  int          n_cmp, n_fail;

  for (genvar i = 0; i < 16; i++) begin : g_tb_nets
    assign bus_a[i]  = bus_oe ? bus_val[i] : 1'bz;
    assign bus_b[i]  = bus_oe ? bus_val[i] : 1'bz;
    assign pads_a[i] = pad_oe[i] ? pad_val[i] : 1'bz;
    pullup (bus_a[i]);
    pullup (bus_b[i]);
    pullup (pads_a[i]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_tb_pads_b
    pullup (pads_b[i]);
  end

  gpio_port_edge #(.WIDTH(16), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rstn(rstn), .GPort_busAddr(addr), .GPort_busWr(wr), .GPort_busEn(en),
    .GPort_busData(bus_a), .GPort_extPin(pads_a), .GPort_irq(irq_a)
  );

  gpio_port_edge #(.WIDTH(4), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .GPort_busAddr(addr), .GPort_busWr(wr), .GPort_busEn(en),
    .GPort_busData(bus_b), .GPort_extPin(pads_b), .GPort_irq(irq_b)
  );

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wr = 1'b1; en = 1'b1; bus_oe = 1'b1; bus_val = d;
    @(negedge clk);
    wr = 1'b0; en = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    @(negedge clk);
    addr = a; wr = 1'b0; en = 1'b1;
    #1;
    rd_a = bus_a; rd_b = bus_b;
    en = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; wr = 1'b0; addr = 3'd0;
    #2;
    n_cmp++; if (bus_a !== 16'hFFFF) begin n_fail++; $display("FAIL rst_bus_z got=%h exp=%h", bus_a, 16'hFFFF); end
    n_cmp++; if (pads_a !== 16'hFFFF) begin n_fail++; $display("FAIL rst_pads_z got=%h exp=%h", pads_a, 16'hFFFF); end
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq_a); end
    #20;
    n_cmp++; if (bus_a !== 16'hFFFF) begin n_fail++; $display("FAIL rst_bus_z_clocked got=%h exp=%h", bus_a, 16'hFFFF); end
    en = 1'b0;
    @(negedge clk) rstn = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(3'd0);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL rst_dir got=%h exp=%h", rd_a, 16'h0000); end
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL rst_iflag got=%h exp=%h", rd_a, 16'h0000); end
    bus_read(3'd2);
    n_cmp++; if (rd_a !== 16'hFFFF) begin n_fail++; $display("FAIL rst_in got=%h exp=%h", rd_a, 16'hFFFF); end
  endtask

  task automatic test_dir_out();
    bus_write(3'd0, 16'h00FF);
    bus_write(3'd1, 16'h00A5);
    #1;
    n_cmp++; if (pads_a !== 16'hFFA5) begin n_fail++; $display("FAIL dir_out_pads got=%h exp=%h", pads_a, 16'hFFA5); end
    bus_read(3'd1);
    n_cmp++; if (rd_a !== 16'h00A5) begin n_fail++; $display("FAIL out_readback got=%h exp=%h", rd_a, 16'h00A5); end
    repeat (3) @(negedge clk);
    bus_read(3'd2);
    n_cmp++; if (rd_a !== 16'hFFA5) begin n_fail++; $display("FAIL in_of_outputs got=%h exp=%h", rd_a, 16'hFFA5); end
    bus_write(3'd5, 16'hFFFF);
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL iflag_w1c_all got=%h exp=%h", rd_a, 16'h0000); end
  endtask

  task automatic test_otgl();
    bus_write(3'd1, 16'h0F0F);
    bus_write(3'd6, 16'h00FF);
    bus_read(3'd1);
    n_cmp++; if (rd_a !== 16'h0FF0) begin n_fail++; $display("FAIL otgl_out got=%h exp=%h", rd_a, 16'h0FF0); end
    bus_read(3'd6);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL otgl_read got=%h exp=%h", rd_a, 16'h0000); end
    bus_write(3'd7, 16'hFFFF);
    bus_read(3'd0);
    n_cmp++; if (rd_a !== 16'h00FF) begin n_fail++; $display("FAIL addr7_no_effect got=%h exp=%h", rd_a, 16'h00FF); end
    bus_read(3'd7);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL addr7_read got=%h exp=%h", rd_a, 16'h0000); end
    bus_write(3'd0, 16'h0000);
  endtask

  task automatic test_edge_irq();
    @(negedge clk);
    pad_oe = 16'h0008; pad_val = 16'h0000;
    repeat (5) @(negedge clk);
    bus_write(3'd5, 16'hFFFF);
    bus_write(3'd4, 16'h0008);
    bus_write(3'd3, 16'h0008);
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL edge_pre_iflag got=%h exp=%h", rd_a, 16'h0000); end
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL edge_pre_irq got=%b exp=0", irq_a); end
    @(negedge clk) pad_val[3] = 1'b1;
    @(posedge clk); #1; addr = 3'd2; en = 1'b1; #1;
    n_cmp++; if (bus_a !== 16'hFFF7) begin n_fail++; $display("FAIL in_after_1_edge got=%h exp=%h", bus_a, 16'hFFF7); end
    en = 1'b0;
    @(posedge clk); #1; en = 1'b1; #1;
    n_cmp++; if (bus_a !== 16'hFFFF) begin n_fail++; $display("FAIL in_after_2_edges got=%h exp=%h", bus_a, 16'hFFFF); end
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_after_2_edges got=%b exp=0", irq_a); end
    en = 1'b0;
    @(posedge clk); #1; addr = 3'd5; en = 1'b1; #1;
    n_cmp++; if (bus_a !== 16'h0008) begin n_fail++; $display("FAIL iflag_after_3_edges got=%h exp=%h", bus_a, 16'h0008); end
    n_cmp++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_after_3_edges got=%b exp=1", irq_a); end
    en = 1'b0;
    bus_write(3'd5, 16'h0008);
    #1;
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c got=%b exp=0", irq_a); end
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    pad_oe = 16'h0009; pad_val = 16'h0008;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    addr = 3'd5; wr = 1'b1; en = 1'b1; bus_oe = 1'b1; bus_val = 16'h0001;
    @(negedge clk);
    wr = 1'b0; en = 1'b0; bus_oe = 1'b0;
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0001) begin n_fail++; $display("FAIL set_beats_clear got=%h exp=%h", rd_a, 16'h0001); end
    bus_write(3'd5, 16'h0001);
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL later_clear got=%h exp=%h", rd_a, 16'h0000); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    addr = 3'd3; wr = 1'b1; en = 1'b1; bus_oe = 1'b1; bus_val = 16'h1234;
    @(negedge clk);
    addr = 3'd4; bus_val = 16'h00C3;
    @(negedge clk);
    wr = 1'b0; en = 1'b0; bus_oe = 1'b0;
    bus_read(3'd3);
    n_cmp++; if (rd_a !== 16'h1234) begin n_fail++; $display("FAIL b2b_ien got=%h exp=%h", rd_a, 16'h1234); end
    bus_read(3'd4);
    n_cmp++; if (rd_a !== 16'h00C3) begin n_fail++; $display("FAIL b2b_ipol got=%h exp=%h", rd_a, 16'h00C3); end
  endtask

  task automatic test_warmup();
    @(negedge clk);
    rstn = 1'b0;
    pad_oe = 16'hFFFF; pad_val = 16'hFFFF;
    addr = 3'd4; wr = 1'b1; en = 1'b1; bus_oe = 1'b1; bus_val = 16'hFFFF;
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    wr = 1'b0; en = 1'b0; bus_oe = 1'b0;
    repeat (9) @(negedge clk);
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL warmup_iflag got=%h exp=%h", rd_a, 16'h0000); end
    bus_write(3'd3, 16'hFFFF);
    #1;
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL warmup_irq got=%b exp=0", irq_a); end
    bus_write(3'd4, 16'hFFDF);
    repeat (3) @(negedge clk);
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL ipol_write_no_event got=%h exp=%h", rd_a, 16'h0000); end
    @(negedge clk) pad_val[5] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL fall_pad5_irq got=%b exp=1", irq_a); end
    bus_read(3'd5);
    n_cmp++; if (rd_a !== 16'h0020) begin n_fail++; $display("FAIL fall_pad5_iflag got=%h exp=%h", rd_a, 16'h0020); end
  endtask

  task automatic test_width4_reset();
    @(negedge clk) pad_oe = 16'h0000;
    bus_write(3'd0, 16'hFFFF);
    bus_read(3'd0);
    n_cmp++; if (rd_b !== 16'h000F) begin n_fail++; $display("FAIL w4_dir_read got=%h exp=%h", rd_b, 16'h000F); end
    n_cmp++; if (pads_b !== 4'h0) begin n_fail++; $display("FAIL w4_pads_driven got=%h exp=%h", pads_b, 4'h0); end
    @(negedge clk);
    addr = 3'd0; wr = 1'b0; en = 1'b1;
    #1;
    n_cmp++; if (bus_b !== 16'h000F) begin n_fail++; $display("FAIL w4_mid_read got=%h exp=%h", bus_b, 16'h000F); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (bus_b !== 16'hFFFF) begin n_fail++; $display("FAIL w4_bus_z_on_rst got=%h exp=%h", bus_b, 16'hFFFF); end
    n_cmp++; if (pads_b !== 4'hF) begin n_fail++; $display("FAIL w4_pads_z_on_rst got=%h exp=%h", pads_b, 4'hF); end
    en = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    addr = 3'd1; wr = 1'b1; en = 1'b1; bus_oe = 1'b1; bus_val = 16'hFFFF;
    #2 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; en = 1'b0; bus_oe = 1'b0; rstn = 1'b1;
    bus_read(3'd1);
    n_cmp++; if (rd_a !== 16'h0000) begin n_fail++; $display("FAIL aborted_write_a got=%h exp=%h", rd_a, 16'h0000); end
    n_cmp++; if (rd_b !== 16'h0000) begin n_fail++; $display("FAIL aborted_write_b got=%h exp=%h", rd_b, 16'h0000); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rstn = 1'b0; addr = 3'd0; wr = 1'b0; en = 1'b0;
    bus_oe = 1'b0; bus_val = 16'h0000; pad_oe = 16'h0000; pad_val = 16'h0000;
    rd_a = 16'h0000; rd_b = 16'h0000;
    test_reset();
    test_dir_out();
    test_otgl();
    test_edge_irq();
    test_set_wins();
    test_back_to_back();
    test_warmup();
    test_width4_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
